// File: rtl/cp_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cp_pkg;

  localparam int              CP_XLEN     = 32;
  localparam logic [31:0]     CP_RESET_PC = 32'h0000_0000;
  localparam int              CP_INSTR_W  = 32;

  // One fetched instruction as handed to decode.
  typedef struct packed {
    logic [CP_XLEN-1:0]    pc;
    logic [CP_INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/cp_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// Latency: pushed word visible at pop_data the cycle after the push.
// Backpressure: push ignored when full unless a pop happens the same cycle; flush wins over push/pop.
// Ports: clk, rst (async active-high), push/push_data, pop/pop_data, flush, count, full, empty.
module cp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW       = $clog2(DEPTH+1);
  localparam logic [AW-1:0]  LAST     = AW'(DEPTH-1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cp_if_fetch_unit.sv
// Instruction fetch front end: PC, pipelined in-order fetch requests, fetch queue to decode, redirects.
// Latency: response at cycle N appears on the decode port at N+1.
// Backpressure: credit rule (queue + in-flight <= FQ_DEPTH) means responses are never stalled;
//   decode backpressure only throttles new requests.
// Ports: clk, rst; instr_req_o/gnt_i/addr_o request port; instr_rvalid_i/rdata_i response;
//   redirect_i/redirect_pc_i; instr_valid_id_o/ready_id_i/data_id_o/pc_id_o decode stream.
module cp_if_fetch_unit
  import cp_pkg::*;
#(
  parameter int              XLEN      = CP_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(CP_RESET_PC),
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instr_req_o,
  input  logic            instr_gnt_i,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_rvalid_i,
  input  logic [31:0]     instr_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_id_o,
  input  logic            instr_ready_id_i,
  output logic [31:0]     instr_data_id_o,
  output logic [XLEN-1:0] instr_pc_id_o
);

  localparam int            CW        = $clog2(MAX_OUTST+1);
  localparam int            QW        = $clog2(FQ_DEPTH+1);
  localparam int            PW        = XLEN + 32;
  localparam logic [CW-1:0] OUTST_MAX = CW'(MAX_OUTST);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outst;     // requests granted but not yet answered
  logic [CW-1:0]   drop;      // answers still owed to a squashed fetch stream
  logic            issue;
  logic            keep;
  logic            id_pop;
  logic [PW-1:0]   q_head;
  logic [QW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic [XLEN-1:0] tag_head;
  logic [CW-1:0]   tag_count;
  logic            tag_full;
  logic            tag_empty;

  // Only request when the answer is guaranteed a queue slot.
  assign instr_req_o  = !rst && !redirect_i && (outst < OUTST_MAX) &&
                        ((int'(q_count) + int'(outst)) < FQ_DEPTH);
  assign instr_addr_o = pc;
  assign issue        = instr_req_o & instr_gnt_i;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign keep   = instr_rvalid_i && (drop == '0) && !redirect_i;
  assign id_pop = instr_valid_id_o && instr_ready_id_i && !redirect_i;

  assign instr_valid_id_o = !q_empty;
  assign instr_pc_id_o    = q_empty ? '0 : q_head[PW-1:32];
  assign instr_data_id_o  = q_empty ? '0 : q_head[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      outst <= '0;
      drop  <= '0;
    end else if (redirect_i) begin
      pc    <= {redirect_pc_i[XLEN-1:2], 2'b00};
      // Everything still in flight after this cycle is stale.
      outst <= outst - CW'(instr_rvalid_i);
      drop  <= outst - CW'(instr_rvalid_i);
    end else begin
      if (issue) pc <= pc + XLEN'(4);
      outst <= outst + CW'(issue) - CW'(instr_rvalid_i);
      if (instr_rvalid_i && (drop != '0)) drop <= drop - CW'(1);
    end
  end

  cp_fifo #(.WIDTH(PW), .DEPTH(FQ_DEPTH)) u_fetch_q (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data ({tag_head, instr_rdata_i}),
    .pop       (id_pop),
    .flush     (redirect_i),
    .pop_data  (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // PC of each in-flight request, so responses can be labelled in order.
  // Never flushed: squashed responses still arrive and must pop their tag.
  cp_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (pc),
    .pop       (instr_rvalid_i),
    .flush     (1'b0),
    .pop_data  (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  a_rvalid_needs_outst: assert property (@(posedge clk) disable iff (rst)
    instr_rvalid_i |-> (outst != '0) && !tag_empty);
  a_tag_tracks_outst: assert property (@(posedge clk) disable iff (rst)
    tag_count == outst);
  a_no_tag_overflow: assert property (@(posedge clk) disable iff (rst)
    issue |-> !tag_full);
  a_no_queue_overflow: assert property (@(posedge clk) disable iff (rst)
    keep |-> (!q_full || id_pop));

endmodule

// File: tb/tb_cp_if_fetch_unit.sv
module tb_cp_if_fetch_unit;
  import cp_pkg::*;

  logic        clk;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_data;
  logic [31:0] id_pc;

  cp_if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(4), .MAX_OUTST(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_req_o      (req),
    .instr_gnt_i      (gnt),
    .instr_addr_o     (addr),
    .instr_rvalid_i   (rvalid),
    .instr_rdata_i    (rdata),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .instr_valid_id_o (id_valid),
    .instr_ready_id_i (id_ready),
    .instr_data_id_o  (id_data),
    .instr_pc_id_o    (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          gnt_pct  = 0;
  int          rv_pct   = 0;
  int          cyc      = 0;
  int          grant_cnt = 0;
  logic [31:0] pend_q[$];
  fetch_pkt_t  hs_q[$];
  int          hs_cyc_q[$];
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_data;

  // One clock cycle, entered and left at a falling edge. The memory model answers
  // in order, at least one cycle after the grant, with word = ~address.
  task automatic step();
    gnt = ($urandom_range(0, 99) < gnt_pct);
    if (pend_q.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
      rvalid = 1'b1;
      rdata  = ~pend_q[0];
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
    #1;
    s_req   = req;
    s_addr  = addr;
    s_valid = id_valid;
    s_pc    = id_pc;
    s_data  = id_data;
    @(posedge clk);
    if (s_req && gnt) begin
      pend_q.push_back(s_addr);
      grant_cnt++;
    end
    if (rvalid) void'(pend_q.pop_front());
    if (s_valid && id_ready && !redirect) begin
      hs_q.push_back('{pc: s_pc, instr: s_data});
      hs_cyc_q.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    pend_q.delete(); hs_q.delete(); hs_cyc_q.delete();
    cyc = 0; grant_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", req); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", id_valid); end
    n_checks++; if (id_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", id_data); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", id_pc); end
    rst = 1'b0;
    gnt_pct = 100; rv_pct = 100; id_ready = 1'b0;
    step();
    n_checks++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %0b want 1", s_req); end
    n_checks++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 0", s_addr); end
    repeat (4) step();
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %0b want 1", id_valid); end
    // Reset asserted between edges must clear outputs without waiting for a clock.
    #2 rst = 1'b1;
    rvalid = 1'b0;
    #1;
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL midreset_req: got %0b want 0", req); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %0b want 0", id_valid); end
    n_checks++; if (id_data !== 32'h0) begin n_fail++; $display("FAIL midreset_data: got %h want 0", id_data); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL midreset_pc: got %h want 0", id_pc); end
    pend_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL post_reset_addr: got %h want 0", s_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    gnt_pct = 100; rv_pct = 100; id_ready = 1'b1;
    repeat (7) step();
    for (int i = 0; i < 4; i++) begin
      e = 32'(4 * i);
      n_checks++;
      if (i >= hs_q.size()) begin
        n_fail++; $display("FAIL stream_count: got %0d packets want >=4", hs_q.size());
      end else begin
        if (hs_q[i].pc !== e) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, hs_q[i].pc, e); end
        n_checks++; if (hs_q[i].instr !== ~e) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, hs_q[i].instr, ~e); end
        n_checks++; if (hs_cyc_q[i] != 2 + i) begin n_fail++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, hs_cyc_q[i], 2 + i); end
      end
    end
  endtask

  task automatic test_id_stall();
    logic [31:0] e;
    do_reset();
    gnt_pct = 100; rv_pct = 100; id_ready = 1'b0;
    repeat (10) step();
    n_checks++; if (grant_cnt != 4) begin n_fail++; $display("FAIL stall_grants: got %0d want 4", grant_cnt); end
    n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %0b want 0", s_req); end
    n_checks++; if (pend_q.size() != 0) begin n_fail++; $display("FAIL stall_inflight: got %0d want 0", pend_q.size()); end
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head: got valid %0b pc %h want 1 0", id_valid, id_pc); end
    id_ready = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 6; i++) begin
      e = 32'(4 * i);
      n_checks++;
      if (i >= hs_q.size()) begin
        n_fail++; $display("FAIL resume_count: got %0d packets want >=6", hs_q.size());
      end else if (hs_q[i].pc !== e || hs_q[i].instr !== ~e) begin
        n_fail++; $display("FAIL resume_pkt[%0d]: got %h/%h want %h/%h", i, hs_q[i].pc, hs_q[i].instr, e, ~e);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    gnt_pct = 100; rv_pct = 0; id_ready = 1'b1;
    repeat (3) step();
    n_checks++; if (s_req !== 1'b0 || grant_cnt != 2) begin n_fail++; $display("FAIL redir_outst: got req %0b grants %0d want 0 2", s_req, grant_cnt); end
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %0b want 0", s_req); end
    redirect = 1'b0;
    step();
    n_checks++; if (s_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %h want 100", s_addr); end
    rv_pct = 100;
    repeat (10) step();
    n_checks++;
    if (hs_q.size() < 2) begin
      n_fail++; $display("FAIL redir_count: got %0d packets want >=2", hs_q.size());
    end else begin
      if (hs_q[0].pc !== 32'h100 || hs_q[0].instr !== ~32'h100) begin
        n_fail++; $display("FAIL redir_first: got %h/%h want 100/%h", hs_q[0].pc, hs_q[0].instr, ~32'h100);
      end
      n_checks++; if (hs_q[1].pc !== 32'h104) begin n_fail++; $display("FAIL redir_second: got %h want 104", hs_q[1].pc); end
    end
  endtask

  task automatic test_redirect_with_rvalid();
    do_reset();
    gnt_pct = 100; rv_pct = 0; id_ready = 1'b1;
    step();
    gnt_pct = 0; rv_pct = 100;
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    n_checks++; if (s_req !== 1'b0 || pend_q.size() != 0) begin n_fail++; $display("FAIL rvredir_state: got req %0b inflight %0d want 0 0", s_req, pend_q.size()); end
    redirect = 1'b0; gnt_pct = 100;
    repeat (6) step();
    n_checks++;
    if (hs_q.size() < 1) begin
      n_fail++; $display("FAIL rvredir_count: got %0d packets want >=1", hs_q.size());
    end else if (hs_q[0].pc !== 32'h200 || hs_q[0].instr !== ~32'h200) begin
      n_fail++; $display("FAIL rvredir_first: got %h/%h want 200/%h", hs_q[0].pc, hs_q[0].instr, ~32'h200);
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    gnt_pct = 0; rv_pct = 0; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL gstall[%0d]: got req %0b addr %h want 1 0", i, s_req, s_addr); end
    end
    gnt_pct = 100;
    step();
    gnt_pct = 0;
    step();
    n_checks++; if (s_addr !== 32'h4 || grant_cnt != 1) begin n_fail++; $display("FAIL gstall_next: got addr %h grants %0d want 4 1", s_addr, grant_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] arch;
    fetch_pkt_t  p;
    int          n_hs;
    int          bad;
    do_reset();
    arch = 32'h0; n_hs = 0; bad = 0;
    gnt_pct = 50; rv_pct = 60;
    for (int c = 0; c < 1500; c++) begin
      id_ready    = ($urandom_range(0, 99) < 70);
      redirect    = ($urandom_range(0, 99) < 4);
      redirect_pc = 32'($urandom_range(0, 16'hFFFF));
      step();
      while (hs_q.size() > 0) begin
        p = hs_q.pop_front();
        n_hs++;
        n_checks++;
        if ((p.pc !== arch || p.instr !== ~arch) && bad < 5) begin
          n_fail++; bad++;
          $display("FAIL rand_pkt[%0d]: got %h/%h want %h/%h", n_hs, p.pc, p.instr, arch, ~arch);
        end else if (p.pc !== arch || p.instr !== ~arch) begin
          n_fail++;
        end
        arch = arch + 32'h4;
      end
      if (redirect) arch = {redirect_pc[31:2], 2'b00};
    end
    redirect = 1'b0;
    n_checks++; if (n_hs < 100) begin n_fail++; $display("FAIL rand_progress: got %0d packets want >=100", n_hs); end
  endtask

  initial begin
    rst = 1'b1;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    test_reset();
    test_stream();
    test_id_stall();
    test_redirect();
    test_redirect_with_rvalid();
    test_gnt_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
